// File: rtl/and_or_pipe.sv
// Elastic valid/ready pipeline computing x = a & b and y = b | c.
// LATENCY stages; bubbles collapse and occupancy tracks the number of valid stages.
module and_or_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 2,
    localparam int unsigned OCC_W  = $clog2(LATENCY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [OCC_W-1:0] occupancy
);

    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   x_q [LATENCY];
    logic [WIDTH-1:0]   y_q [LATENCY];
    logic [OCC_W-1:0]   occ_q, occ_d;

    logic [LATENCY-1:0] ready;
    logic [LATENCY-1:0] in_v;
    logic [WIDTH-1:0]   in_x [LATENCY];
    logic [WIDTH-1:0]   in_y [LATENCY];
    logic               push, pop;

    // Stage k may load if it, or any stage downstream of it, is empty, or the
    // last stage is being drained. Built from the tail so there is no comb loop.
    always_comb begin
        logic acc;
        ready = '0;
        acc   = out_ready;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            acc      = acc | ~valid_q[k];
            ready[k] = acc;
        end
    end

    always_comb begin
        in_v    = '0;
        in_v[0] = in_valid;
        in_x[0] = a & b;
        in_y[0] = b | c;
        for (int k = 1; k < LATENCY; k++) begin
            in_v[k] = valid_q[k-1];
            in_x[k] = x_q[k-1];
            in_y[k] = y_q[k-1];
        end
    end

    assign push = in_valid & ready[0];
    assign pop  = valid_q[LATENCY-1] & out_ready;

    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Data only loads alongside a valid bit, so idle operand values never reach state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int k = 0; k < LATENCY; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= in_v[k];
                    if (in_v[k]) begin
                        x_q[k] <= in_x[k];
                        y_q[k] <= in_y[k];
                    end
                end
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[LATENCY-1];
    assign x         = x_q[LATENCY-1];
    assign y         = y_q[LATENCY-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_and_or_pipe.sv
// Directed bench for and_or_pipe (WIDTH=8, LATENCY=2) with hand-computed expectations.
module tb_and_or_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b, c;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] x, y;
    logic [1:0] occupancy;

    int checks = 0;
    int errors = 0;

    and_or_pipe #(.WIDTH(8), .LATENCY(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] cv);
        in_valid = v;
        a = av;
        b = bv;
        c = cv;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 8'h00;
        b = 8'h00;
        c = 8'h00;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_x", 32'(x), 32'h00);
        chk("rst_y", 32'(y), 32'h00);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single transaction
        tick();
        out_ready = 1'b1;
        drive(1'b1, 8'hF0, 8'h3C, 8'h01);
        chk("single_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 8'hFF, 8'hFF, 8'hFF);
        chk("single_early_valid", 32'(out_valid), 32'd0);
        chk("single_occ1", 32'(occupancy), 32'd1);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_x", 32'(x), 32'h30);
        chk("single_y", 32'(y), 32'h3D);
        tick();
        chk("single_valid_drop", 32'(out_valid), 32'd0);
        chk("single_occ0", 32'(occupancy), 32'd0);

        // Back-to-back stream
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1'b1, 8'(i), 8'hFF, 8'h00);
            else        drive(1'b0, 8'h00, 8'h00, 8'h00);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2) begin
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_x", 32'(x), 32'(i - 2));
                chk("stream_y", 32'(y), 32'hFF);
            end else begin
                chk("stream_valid_lead", 32'(out_valid), 32'd0);
            end
            chk("stream_occ", 32'(occupancy), (i == 0) ? 32'd0 : (i == 1 || i == 17) ? 32'd1 : 32'd2);
            tick();
        end
        chk("stream_drained", 32'(out_valid), 32'd0);
        chk("stream_occ_end", 32'(occupancy), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 8'h44);
        chk("bp_ready_a", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 8'h3C, 8'hF0, 8'h0F);
        chk("bp_ready_b", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 8'hFF, 8'h81, 8'h18);
        chk("bp_occ_full", 32'(occupancy), 32'd2);
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_x_a", 32'(x), 32'h00);
        chk("bp_y_a", 32'(y), 32'h66);
        for (int s = 0; s < 2; s++) begin
            tick();
            chk("bp_stall_valid", 32'(out_valid), 32'd1);
            chk("bp_stall_x", 32'(x), 32'h00);
            chk("bp_stall_y", 32'(y), 32'h66);
            chk("bp_stall_occ", 32'(occupancy), 32'd2);
            chk("bp_stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        chk("bp_x_b", 32'(x), 32'h30);
        chk("bp_y_b", 32'(y), 32'hFF);
        chk("bp_occ_b", 32'(occupancy), 32'd2);
        tick();
        chk("bp_valid_c", 32'(out_valid), 32'd1);
        chk("bp_x_c", 32'(x), 32'h81);
        chk("bp_y_c", 32'(y), 32'h99);
        chk("bp_occ_c", 32'(occupancy), 32'd1);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_occ_end", 32'(occupancy), 32'd0);

        // Simultaneous push and pop on a full pipe
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h0F, 8'h80);
        tick();
        drive(1'b1, 8'h02, 8'h0F, 8'h80);
        tick();
        chk("sim_full_occ", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 8'(3 + j), 8'h0F, 8'h80);
            chk("sim_in_ready", 32'(in_ready), 32'd1);
            chk("sim_occ", 32'(occupancy), 32'd2);
            chk("sim_valid", 32'(out_valid), 32'd1);
            chk("sim_x", 32'(x), 32'(j + 1));
            chk("sim_y", 32'(y), 32'h8F);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        chk("sim_tail_x6", 32'(x), 32'h06);
        tick();
        chk("sim_tail_x7", 32'(x), 32'h07);
        tick();
        chk("sim_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-flight
        out_ready = 1'b0;
        drive(1'b1, 8'hAA, 8'hFF, 8'h00);
        tick();
        drive(1'b1, 8'h55, 8'hFF, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        chk("mid_occ_full", 32'(occupancy), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_x", 32'(x), 32'h00);
        chk("mid_rst_y", 32'(y), 32'h00);
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end

        // Bubbles: in_valid 1,0,1,0,...
        for (int s = 0; s < 10; s++) begin
            if (s < 8 && (s % 2) == 0) drive(1'b1, 8'hC0 | 8'(s), 8'h0F, 8'h30);
            else                       drive(1'b0, 8'hEE, 8'hEE, 8'hEE);
            chk("bub_occ", 32'(occupancy), (s >= 1 && s <= 8) ? 32'd1 : 32'd0);
            if (s >= 2 && (s % 2) == 0) begin
                chk("bub_valid", 32'(out_valid), 32'd1);
                chk("bub_x", 32'(x), 32'(s - 2));
                chk("bub_y", 32'(y), 32'h3F);
            end else begin
                chk("bub_gap", 32'(out_valid), 32'd0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
